aurora_tx_buffer: RTL and testbench



---
 rtl/aurora_pkg.sv | 26 ++
 rtl/aurora_tx_buffer_fifo.sv | 64 ++++++
 rtl/aurora_tx_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_aurora_tx_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// aurora_pkg: shared types and constants for the Aurora transmit path.
//   AXI_DATA_SIZE      - width of one user/Aurora data word
//   tx_buffer_state_e  - frame-sequencer state of aurora_tx_buffer
//   tx_word_t          - one buffered word: {last, data}
//   max_int()          - helper for sizing counters from two parameters
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;

  typedef enum logic {
    TXB_IDLE,
    TXB_SEND
  } tx_buffer_state_e;

  typedef struct packed {
    logic                     last;
    logic [AXI_DATA_SIZE-1:0] data;
  } tx_word_t;

  localparam int TX_WORD_W = $bits(tx_word_t);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aurora_tx_buffer_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read port.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (ignored when full)
//   push_data   - word to store
//   pop         - advance the read pointer (ignored when empty)
//   head        - oldest stored word, valid whenever empty=0; after a pop
//                 the next word appears the following cycle
//   full/empty  - occupancy flags
//   level       - current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  // Show-ahead: the word at the read pointer is always visible, so the
  // consumer can register it on the same edge that pops it.
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/aurora_tx_buffer.sv
// aurora_tx_buffer: store-and-forward frame buffer in front of the Aurora
// transmit top level, which has no ready signal of its own.
//
// Handshake: a user beat transfers on a clk edge where s_axis_tvalid and
// s_axis_tready are both 1; s_axis_tready is registered and equals "FIFO not
// full" for the current cycle. The Aurora side has no ready: axi_valid /
// axi_last / axi_data change only on a pace strobe and hold for one period.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   single_lane    - 1: SINGLE_LANE_DIV clk per word, 0: MULTI_LANE_DIV
//   tx_enable      - permits starting a new frame (an open frame completes)
//   s_axis_*       - user AXI4-Stream input (tvalid/tready/tdata/tlast)
//   axi_valid/last/data - paced word stream to the Aurora top level
//   fifo_level     - current FIFO occupancy
//   underrun       - sticky, set when a bubble is inserted mid-frame
// Optional (macro AURORA_TX_BUFFER_STATS_EN):
//   frames_sent    - count of last words presented (wraps)
//   max_level      - high-water mark of fifo_level
//
// The FIFO uses a show-ahead read: the head word is registered into the
// output on the strobe edge that pops it, so no early pop is needed.
module aurora_tx_buffer
  import aurora_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter int SINGLE_LANE_DIV = 4,
  parameter int MULTI_LANE_DIV  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     single_lane,
  input  logic                     tx_enable,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AXI_DATA_SIZE-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  output logic                     axi_valid,
  output logic                     axi_last,
  output logic [AXI_DATA_SIZE-1:0] axi_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun
`ifdef AURORA_TX_BUFFER_STATS_EN
  ,
  output logic [31:0]              frames_sent,
  output logic [$clog2(DEPTH):0]   max_level
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(max_int(SINGLE_LANE_DIV, MULTI_LANE_DIV)) + 1;

  tx_buffer_state_e state;
  tx_word_t         wr_word;
  tx_word_t         head_word;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             start_ok;
  logic [LW-1:0]    frame_cnt;
  logic [LW-1:0]    level_next;

  // ---------------------------------------------------------------- FIFO
  assign push    = s_axis_tvalid && s_axis_tready;
  assign wr_word = {s_axis_tlast, s_axis_tdata};

  sync_fifo #(
    .WIDTH (TX_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_word),
    .pop       (pop),
    .head      (head_word),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // tready is registered from the next-cycle occupancy so it reads 0 in
  // reset and rises on the first edge after release.
  always_comb begin
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + LW'(1);
    else if (!push && pop) level_next = fifo_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_axis_tready <= 1'b0;
    else        s_axis_tready <= (level_next != LW'(DEPTH));
  end

  // ------------------------------------------------------- pace counter
  logic [PW-1:0] pace_cnt;
  logic [PW-1:0] pace_last;
  logic          prev_lane;
  logic          lane_chg;
  logic          strobe;

  assign pace_last = single_lane ? PW'(SINGLE_LANE_DIV - 1) : PW'(MULTI_LANE_DIV - 1);
  // A lane-mode change restarts the period and suppresses that cycle's
  // strobe so a word is never cut short or repeated.
  assign lane_chg  = (single_lane != prev_lane);
  assign strobe    = !lane_chg && (pace_cnt == pace_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pace_cnt  <= '0;
      prev_lane <= 1'b0;
    end else begin
      prev_lane <= single_lane;
      if (lane_chg || pace_cnt == pace_last) pace_cnt <= '0;
      else                                   pace_cnt <= pace_cnt + PW'(1);
    end
  end

  // ------------------------------------------------------ frame counter
  // Complete frames held: a full FIFO with frame_cnt=0 means an oversize
  // frame, which is then started cut-through.
  assign start_ok = tx_enable && (frame_cnt != '0 || full) && !empty;

  always_comb begin
    pop = 1'b0;
    if (strobe) begin
      if (state == TXB_IDLE) pop = start_ok;
      else                   pop = !empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else begin
      case ({push && s_axis_tlast, pop && head_word.last})
        2'b10:   frame_cnt <= frame_cnt + LW'(1);
        2'b01:   frame_cnt <= frame_cnt - LW'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  // ---------------------------------------------- sequencer and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TXB_IDLE;
      axi_valid <= 1'b0;
      axi_last  <= 1'b0;
      axi_data  <= '0;
      underrun  <= 1'b0;
    end else if (strobe) begin
      case (state)
        TXB_IDLE: begin
          if (start_ok) begin
            axi_valid <= 1'b1;
            axi_last  <= head_word.last;
            axi_data  <= head_word.data;
            if (!head_word.last) state <= TXB_SEND;
          end else begin
            axi_valid <= 1'b0;
            axi_last  <= 1'b0;
          end
        end
        TXB_SEND: begin
          // tx_enable is deliberately ignored: an open frame always ends.
          if (!empty) begin
            axi_valid <= 1'b1;
            axi_last  <= head_word.last;
            axi_data  <= head_word.data;
            if (head_word.last) state <= TXB_IDLE;
          end else begin
            axi_valid <= 1'b0;
            axi_last  <= 1'b0;
            underrun  <= 1'b1;
          end
        end
        default: begin
          state     <= TXB_IDLE;
          axi_valid <= 1'b0;
          axi_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AURORA_TX_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent <= '0;
      max_level   <= '0;
    end else begin
      if (pop && head_word.last) frames_sent <= frames_sent + 32'd1;
      if (fifo_level > max_level) max_level <= fifo_level;
    end
  end
`endif

endmodule

// File: tb/tb_aurora_tx_buffer.sv
// tb_aurora_tx_buffer: directed bench for aurora_tx_buffer (DEPTH=16,
// SINGLE_LANE_DIV=4, MULTI_LANE_DIV=1). Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
module tb_aurora_tx_buffer;
  import aurora_pkg::*;

  localparam int W     = AXI_DATA_SIZE;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          single_lane = 1'b0;
  logic          tx_enable = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          axi_valid;
  logic          axi_last;
  logic [W-1:0]  axi_data;
  logic [LW-1:0] fifo_level;
  logic          underrun;
`ifdef AURORA_TX_BUFFER_STATS_EN
  logic [31:0]   frames_sent;
  logic [LW-1:0] max_level;
`endif

  aurora_tx_buffer #(
    .DEPTH           (DEPTH),
    .SINGLE_LANE_DIV (4),
    .MULTI_LANE_DIV  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .single_lane   (single_lane),
    .tx_enable     (tx_enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .axi_valid     (axi_valid),
    .axi_last      (axi_last),
    .axi_data      (axi_data),
    .fifo_level    (fifo_level),
    .underrun      (underrun)
`ifdef AURORA_TX_BUFFER_STATS_EN
    ,
    .frames_sent   (frames_sent),
    .max_level     (max_level)
`endif
  );

  // -------------------------------------------------------- scoreboard
  logic [W:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int words_tx = 0;
  int words_rx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: an independent model of the pacing period tells when a
  // new word may appear; every word presented must be the next one pushed.
  int   m_cnt = 0;
  int   m_per;
  logic m_prev = 1'b0;
  logic m_chg;
  logic m_strobe = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt    = 0;
      m_prev   = 1'b0;
      m_strobe = 1'b0;
    end else begin
      m_per    = single_lane ? 4 : 1;
      m_chg    = (single_lane != m_prev);
      m_strobe = !m_chg && (m_cnt == m_per - 1);
      if (m_chg || m_cnt == m_per - 1) m_cnt = 0;
      else                             m_cnt = m_cnt + 1;
      m_prev = single_lane;
    end
    #1;
    if (rst_n && m_strobe && axi_valid) begin
      words_rx++;
      if (exp_q.size() == 0) check("extra_word", 64'(exp_q.size()), 64'd1);
      else                   check("word", 64'({axi_last, axi_data}), 64'(exp_q.pop_front()));
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [W-1:0] d, input logic l);
    logic hs;
    int   budget;
    budget        = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    do begin
      hs = s_axis_tready;
      tick();
      budget++;
    end while (!hs && budget < 200);
    check("push_handshake", 64'(hs), 64'd1);
    if (hs) begin
      exp_q.push_back({l, d});
      words_tx++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!axi_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(axi_valid), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Count consecutive samples showing the given word.
  task automatic hold_len(input logic [W-1:0] d, output int n);
    n = 0;
    while (axi_valid && axi_data == d && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------- stimulus
  initial begin
    int n;

    // Reset / idle
    repeat (5) tick();
    check("rst_valid", 64'(axi_valid), 64'd0);
    check("rst_last", 64'(axi_last), 64'd0);
    check("rst_data", 64'(axi_data), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    tick();
    check("tready_after_rst", 64'(s_axis_tready), 64'd1);
    check("idle_valid", 64'(axi_valid), 64'd0);

    // Store-and-forward, multi-lane pacing
    tx_enable = 1'b1;
    push_beat(32'hA1, 1'b0);
    repeat (3) tick();
    check("sf_hold1_valid", 64'(axi_valid), 64'd0);
    check("sf_level1", 64'(fifo_level), 64'd1);
    push_beat(32'hA2, 1'b0);
    repeat (3) tick();
    check("sf_hold2_valid", 64'(axi_valid), 64'd0);
    push_beat(32'hA3, 1'b1);
    check("sf_not_yet", 64'(axi_valid), 64'd0);
    tick();
    check("sf_w1", 64'({axi_valid, axi_last, axi_data}), 64'({1'b1, 1'b0, 32'hA1}));
    tick();
    check("sf_w2", 64'({axi_valid, axi_last, axi_data}), 64'({1'b1, 1'b0, 32'hA2}));
    tick();
    check("sf_w3", 64'({axi_valid, axi_last, axi_data}), 64'({1'b1, 1'b1, 32'hA3}));
    tick();
    check("sf_end_valid", 64'(axi_valid), 64'd0);

    // Single-lane pacing: each word held 4 cycles
    single_lane = 1'b1;
    push_beat(32'hB1, 1'b0);
    push_beat(32'hB2, 1'b1);
    wait_valid("pace_start", 50);
    hold_len(32'hB1, n);
    check("pace_b1_hold", 64'(n), 64'd4);
    check("pace_b2_last", 64'({axi_valid, axi_last}), 64'({1'b1, 1'b1}));
    hold_len(32'hB2, n);
    check("pace_b2_hold", 64'(n), 64'd4);
    check("pace_end_valid", 64'(axi_valid), 64'd0);

    // Backpressure: 16 single-beat frames while disabled
    single_lane = 1'b0;
    tx_enable   = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < DEPTH; i++) push_beat(32'h100 + 32'(i), 1'b1);
    check("bp_tready_full", 64'(s_axis_tready), 64'd0);
    check("bp_level_full", 64'(fifo_level), 64'd16);
    check("bp_no_output", 64'(axi_valid), 64'd0);
    tx_enable = 1'b1;
    tick();
    check("bp_first_word", 64'({axi_valid, axi_data}), 64'({1'b1, 32'h100}));
    check("bp_tready_back", 64'(s_axis_tready), 64'd1);
    wait_drain("bp_drain", 60);
    check("bp_level_empty", 64'(fifo_level), 64'd0);

    // Oversize frame: cut-through once full, producer stalls long enough
    // for the FIFO to run dry mid-frame
    for (int i = 0; i < 16; i++) push_beat(32'hC00 + 32'(i), 1'b0);
    check("os_level_full", 64'(fifo_level), 64'd16);
    check("os_underrun_pre", 64'(underrun), 64'd0);
    repeat (20) tick();
    check("os_underrun_set", 64'(underrun), 64'd1);
    for (int i = 16; i < 20; i++) push_beat(32'hC00 + 32'(i), i == 19);
    wait_drain("os_drain", 60);

    // tx_enable drop and lane toggles in the middle of a frame
    single_lane = 1'b1;
    for (int i = 0; i < 4; i++) push_beat(32'hD0 + 32'(i), i == 3);
    wait_valid("mid_start", 50);
    tx_enable = 1'b0;
    repeat (2) tick();
    single_lane = 1'b0;
    repeat (2) tick();
    single_lane = 1'b1;
    wait_drain("mid_drain", 100);
    check("mid_level", 64'(fifo_level), 64'd0);
    check("underrun_sticky", 64'(underrun), 64'd1);
    repeat (8) tick();
    check("word_count", 64'(words_rx), 64'(words_tx));
    check("end_tready", 64'(s_axis_tready), 64'd1);
`ifdef AURORA_TX_BUFFER_STATS_EN
    check("stats_frames", 64'(frames_sent), 64'd20);
    check("stats_max_level", 64'(max_level), 64'd16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
